// File: rtl/uart_tx_unit_if.sv
// Memory-mapped UART transmit port bundle between the memory controller side
// (master) and the transmitter (slave).
interface uart_tx_unit_if #(
    parameter int UART_Nbit = 8
);
    logic [UART_Nbit-1:0] DataTx_in;
    logic                 enable_StoreTxbuff;
    logic                 Start_uart_tx;
    logic                 clr_tx_flag;
    logic                 SerialDataOut;
    logic                 Tx_busy;
    logic                 Tx_flag;
    logic [UART_Nbit-1:0] TxBuff_out;

    modport master (
        output DataTx_in, enable_StoreTxbuff, Start_uart_tx, clr_tx_flag,
        input  SerialDataOut, Tx_busy, Tx_flag, TxBuff_out
    );

    modport slave (
        input  DataTx_in, enable_StoreTxbuff, Start_uart_tx, clr_tx_flag,
        output SerialDataOut, Tx_busy, Tx_flag, TxBuff_out
    );
endinterface

// File: rtl/uart_tx_unit.sv
// 8N1-style UART transmitter with a software-loaded holding buffer, start strobe
// and sticky frame-complete flag; the serial pin is driven straight from a flop.
module uart_tx_unit #(
    parameter int UART_Nbit = 8,
    parameter int baudrate  = 9600,
    parameter int clk_freq  = 50000000
) (
    input logic           clk,
    input logic           reset,
    uart_tx_unit_if.slave tx
);
    localparam int BAUD_DIV = clk_freq / baudrate;
    localparam int BAUD_W   = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam int BCNT_W   = $clog2(UART_Nbit + 1);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_DIV - 1);
    localparam logic [BCNT_W-1:0] BITS_LAST = BCNT_W'(UART_Nbit - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t               state_q, state_d;
    logic [UART_Nbit-1:0] buff_q, buff_d;
    logic [UART_Nbit-1:0] shift_q, shift_d;
    logic [BCNT_W-1:0]    bcnt_q, bcnt_d;
    logic [BAUD_W-1:0]    baud_q, baud_d;
    logic                 line_q, line_d;
    logic                 flag_q, flag_d;
    logic                 baud_tick;
    logic                 frame_done;

    always_comb begin
        state_d    = state_q;
        buff_d     = buff_q;
        shift_d    = shift_q;
        bcnt_d     = bcnt_q;
        baud_d     = baud_q;
        flag_d     = flag_q;
        line_d     = 1'b1;
        frame_done = 1'b0;
        baud_tick  = (baud_q == BAUD_LAST);

        if (tx.enable_StoreTxbuff) begin
            buff_d = tx.DataTx_in;
        end

        unique case (state_q)
            IDLE: begin
                baud_d = '0;
                bcnt_d = '0;
                if (tx.Start_uart_tx) begin
                    state_d = START;
                    // Store and start in the same cycle sends the freshly written byte
                    shift_d = tx.enable_StoreTxbuff ? tx.DataTx_in : buff_q;
                end
            end
            START: begin
                if (baud_tick) begin
                    baud_d  = '0;
                    state_d = DATA;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            DATA: begin
                if (baud_tick) begin
                    baud_d  = '0;
                    shift_d = shift_q >> 1;
                    bcnt_d  = bcnt_q + BCNT_W'(1);
                    if (bcnt_q == BITS_LAST) begin
                        state_d = STOP;
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            STOP: begin
                if (baud_tick) begin
                    baud_d     = '0;
                    state_d    = IDLE;
                    frame_done = 1'b1;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // Completion outranks a simultaneous software clear
        if (frame_done) begin
            flag_d = 1'b1;
        end else if (tx.clr_tx_flag) begin
            flag_d = 1'b0;
        end

        // Line level is decoded from next state so the pin flop leads the FSM by nothing
        if (state_d == START) begin
            line_d = 1'b0;
        end else if (state_d == DATA) begin
            line_d = shift_d[0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            buff_q  <= '0;
            shift_q <= '0;
            bcnt_q  <= '0;
            baud_q  <= '0;
            line_q  <= 1'b1;
            flag_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            buff_q  <= buff_d;
            shift_q <= shift_d;
            bcnt_q  <= bcnt_d;
            baud_q  <= baud_d;
            line_q  <= line_d;
            flag_q  <= flag_d;
        end
    end

    assign tx.SerialDataOut = line_q;
    assign tx.Tx_busy       = (state_q != IDLE);
    assign tx.Tx_flag       = flag_q;
    assign tx.TxBuff_out    = buff_q;
endmodule
